// File: rtl/tuple_hash_tagger.sv
// tuple_hash_tagger
// -----------------------------------------------------------------------------
// Front-end stage of the partitioner. Each accepted tuple is tagged with the
// murmur3 fmix32 hash of its key (XORed with HASH_SEED first). It also gets a
// per-batch serial number, its last flag and a constant was_joined=0. These
// form the sideband used by the distribution network.
// Three register stages (S1..S3) carry one tuple per cycle. Each stage has
// valid/ready backpressure, so bubbles collapse. S3 drives every output.
//
// Ports:
//   clk                 clock
//   reset               asynchronous, active-high reset
//   in_data             tuple; the key is in_data[KEY_WIDTH-1:0]
//   in_valid            tuple valid
//   in_last             final tuple of a batch
//   in_ready            a tuple is accepted this cycle when in_valid is high
//   out_data            tuple, delayed to line up with its hash
//   out_tag             fmix32(zext(key) ^ HASH_SEED)
//   out_valid           output valid
//   out_last_processed  in_last of this tuple
//   out_serialnum       serial number of this tuple within its batch
//   out_was_joined      always 0 (tuples enter unjoined)
//   out_ready           downstream accepts
// -----------------------------------------------------------------------------
module tuple_hash_tagger #(
  parameter int          INPUT_SIZE = 64,
  parameter int          KEY_WIDTH  = 32,
  parameter logic [31:0] HASH_SEED  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INPUT_SIZE-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [INPUT_SIZE-1:0] out_data,
  output logic [31:0]           out_tag,
  output logic                  out_valid,
  output logic                  out_last_processed,
  output logic [63:0]           out_serialnum,
  output logic                  out_was_joined,
  input  logic                  out_ready
);

  // fmix32 split into three steps, one per pipeline stage.
  // All products are truncated to 32 bits.
  function automatic logic [31:0] fmix_step1(input logic [31:0] h);
    logic [31:0] a;
    a = h ^ (h >> 16);
    return a * 32'h85EB_CA6B;
  endfunction

  function automatic logic [31:0] fmix_step2(input logic [31:0] r);
    logic [31:0] b;
    b = r ^ (r >> 13);
    return b * 32'hC2B2_AE35;
  endfunction

  function automatic logic [31:0] fmix_step3(input logic [31:0] r);
    return r ^ (r >> 16);
  endfunction

  // Stage registers.
  logic                  v1_r, v2_r, v3_r;
  logic [INPUT_SIZE-1:0] data1_r, data2_r, data3_r;
  logic                  last1_r, last2_r, last3_r;
  logic [63:0]           serial1_r, serial2_r, serial3_r;
  logic [31:0]           hash1_r, hash2_r, hash3_r;

  // Batch serial counter. The count shown is the one the next accepted tuple gets.
  logic [63:0]           serial_cnt_r;

  logic [31:0]           key_s;
  logic                  adv1_s, adv2_s, adv3_s;
  logic                  accept_s;

  // Zero-extend the key to 32 bits and apply the seed.
  always_comb begin
    key_s                = 32'h0000_0000;
    key_s[KEY_WIDTH-1:0] = in_data[KEY_WIDTH-1:0];
    key_s                = key_s ^ HASH_SEED;
  end

  // Ready chain from the output back to the input. A stage may load when it
  // is empty or when its content moves on in the same cycle.
  always_comb begin
    adv3_s   = !v3_r || out_ready;
    adv2_s   = !v2_r || adv3_s;
    adv1_s   = !v1_r || adv2_s;
    accept_s = in_valid && adv1_s;
  end

  assign in_ready = adv1_s;

  // Serial counter: advances only on a real input transfer. A batch ends on
  // in_last, and the next batch restarts at 0. Past all-ones the count wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serial_cnt_r <= 64'd0;
    end else if (accept_s) begin
      if (in_last) begin
        serial_cnt_r <= 64'd0;
      end else begin
        serial_cnt_r <= serial_cnt_r + 64'd1;
      end
    end
  end

  // Stage 1: capture the tuple, its serial number and the first hash step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r      <= 1'b0;
      data1_r   <= '0;
      last1_r   <= 1'b0;
      serial1_r <= 64'd0;
      hash1_r   <= 32'h0000_0000;
    end else if (adv1_s) begin
      v1_r      <= in_valid;
      data1_r   <= in_data;
      last1_r   <= in_last;
      serial1_r <= serial_cnt_r;
      hash1_r   <= fmix_step1(key_s);
    end
  end

  // Stage 2: second hash step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r      <= 1'b0;
      data2_r   <= '0;
      last2_r   <= 1'b0;
      serial2_r <= 64'd0;
      hash2_r   <= 32'h0000_0000;
    end else if (adv2_s) begin
      v2_r      <= v1_r;
      data2_r   <= data1_r;
      last2_r   <= last1_r;
      serial2_r <= serial1_r;
      hash2_r   <= fmix_step2(hash1_r);
    end
  end

  // Stage 3: final hash step. This stage drives the outputs, so they hold
  // while a valid result waits for out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_r      <= 1'b0;
      data3_r   <= '0;
      last3_r   <= 1'b0;
      serial3_r <= 64'd0;
      hash3_r   <= 32'h0000_0000;
    end else if (adv3_s) begin
      v3_r      <= v2_r;
      data3_r   <= data2_r;
      last3_r   <= last2_r;
      serial3_r <= serial2_r;
      hash3_r   <= fmix_step3(hash2_r);
    end
  end

  assign out_valid          = v3_r;
  assign out_data           = data3_r;
  assign out_tag            = hash3_r;
  assign out_last_processed = last3_r;
  assign out_serialnum      = serial3_r;
  assign out_was_joined     = 1'b0;

endmodule

// File: tb/tb_tuple_hash_tagger.sv
// Testbench for tuple_hash_tagger.
// A second instance with HASH_SEED=32'hDEADBEEF shares the same inputs.
// A queue-based reference model predicts every output tuple.
module tb_tuple_hash_tagger;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_data;
  logic [31:0] out_tag;
  logic        out_valid;
  logic        out_last_processed;
  logic [63:0] out_serialnum;
  logic        out_was_joined;
  logic        out_ready;

  logic        s_in_ready;
  logic [63:0] s_out_data;
  logic [31:0] s_out_tag;
  logic        s_out_valid;
  logic        s_out_last;
  logic [63:0] s_out_serialnum;
  logic        s_out_was_joined;

  localparam logic [31:0] SEED = 32'hDEAD_BEEF;

  tuple_hash_tagger dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_tag(out_tag), .out_valid(out_valid),
    .out_last_processed(out_last_processed), .out_serialnum(out_serialnum),
    .out_was_joined(out_was_joined), .out_ready(out_ready)
  );

  tuple_hash_tagger #(.HASH_SEED(SEED)) dut_seed (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_tag(s_out_tag), .out_valid(s_out_valid),
    .out_last_processed(s_out_last), .out_serialnum(s_out_serialnum),
    .out_was_joined(s_out_was_joined), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [31:0] tag;
    logic [31:0] stag;
    logic [63:0] serial;
    logic        last;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          accepted = 0;
  bit          free_run = 1'b0;
  bit          hold_pending = 1'b0;
  logic [63:0] held_data, held_serial;
  logic [31:0] held_tag;

  // Reference murmur3 fmix32.
  function automatic logic [31:0] fmix32(input logic [31:0] k);
    logic [31:0] h;
    h = k;
    h = h ^ (h >> 16);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2_AE35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle. Drive the inputs at the falling edge and sample 1ns
  // later. Then record what the next rising edge transfers.
  task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    if (hold_pending) begin
      check_value("hold_valid", {63'd0, out_valid}, 64'd1);
      check_value("hold_data", out_data, held_data);
      check_value("hold_tag", {32'd0, out_tag}, {32'd0, held_tag});
      check_value("hold_serial", out_serialnum, held_serial);
    end
    check_value("seed_valid_align", {63'd0, s_out_valid}, {63'd0, out_valid});
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_value("spurious_output", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check_value("data", out_data, e.data);
        check_value("tag", {32'd0, out_tag}, {32'd0, e.tag});
        check_value("seed_tag", {32'd0, s_out_tag}, {32'd0, e.stag});
        check_value("serialnum", out_serialnum, e.serial);
        check_value("last", {63'd0, out_last_processed}, {63'd0, e.last});
        check_value("was_joined", {63'd0, out_was_joined}, 64'd0);
        if (e.data[31:0] == SEED) check_value("seed_key_zero", {32'd0, s_out_tag}, 64'd0);
        if (free_run) check_value("latency", 64'(cyc - e.acc), 64'd3);
      end
    end
    hold_pending = out_valid && !out_ready;
    held_data = out_data; held_tag = out_tag; held_serial = out_serialnum;
    if (in_valid && in_ready) begin
      e.data = d; e.tag = fmix32(d[31:0]); e.stag = fmix32(d[31:0] ^ SEED);
      e.serial = m_cnt; e.last = l; e.acc = cyc;
      q.push_back(e);
      m_cnt = l ? 64'd0 : m_cnt + 64'd1;
      accepted++;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check_value("drain_empty", 64'(q.size()), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    #1;
    check_value("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check_value("reset_serial_reg", out_serialnum, 64'd0);
    check_value("reset_was_joined", {63'd0, out_was_joined}, 64'd0);
    q.delete(); m_cnt = 64'd0; hold_pending = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("reset_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    m_cnt = 64'd0;
    repeat (2) @(posedge clk);
    apply_reset();

    // 1: key 0 gives tag 0 and serial 0 after 3 cycles.
    free_run = 1'b1;
    cycle(1'b1, 64'd0, 1'b0, 1'b1);
    check_value("t1_tag_model", {32'd0, fmix32(32'd0)}, 64'd0);
    drain();

    // 2: keys 1..8, last on the 8th, then a 9th tuple.
    apply_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), (i == 8), 1'b1);
    cycle(1'b1, 64'd9, 1'b0, 1'b1);
    drain();

    // 3: stall. Only 3 tuples fit, then toggled and random backpressure.
    free_run = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    check_value("stall_accepts", 64'(accepted), 64'd3);
    check_value("stall_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 16; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, (i % 2 == 0));
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(3, 0) != 0), {$urandom, $urandom}, ($urandom_range(7, 0) == 0),
            ($urandom_range(2, 0) != 0));
    drain();

    // 4: key equal to the seed hashes to 0 on the seeded instance.
    free_run = 1'b1;
    cycle(1'b1, {32'h1234_5678, SEED}, 1'b1, 1'b1);
    drain();

    // 5: reset with three tuples in flight.
    cycle(1'b1, 64'hAA, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    check_value("t5_inflight", 64'(q.size()), 64'd3);
    apply_reset();
    cycle(1'b1, 64'h55, 1'b0, 1'b1);
    drain();

    // 6: serial counter wrap from all-ones to zero.
    @(negedge clk);
    force dut.serial_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.serial_cnt_r;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(1'b1, 64'h77, 1'b0, 1'b1);
    cycle(1'b1, 64'h78, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
